// File: rtl/blur_frame_sequencer.sv
// Frame sequencer wrapped around an external blurring filter: it configures the
// kernel between frames, feeds pixels in, and tags filtered pixels with coordinates.
module blur_frame_sequencer #(
    parameter int IMG_W = 15,
    parameter int IMG_H = 15,
    parameter int LAT   = 2,
    parameter int CW    = (IMG_W > IMG_H) ? ((IMG_W > 1) ? $clog2(IMG_W) : 1)
                                          : ((IMG_H > 1) ? $clog2(IMG_H) : 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [2:0]    freq_req,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [11:0]   in_data,
    output logic [2:0]    flt_freq_flag,
    output logic [11:0]   flt_data_in,
    input  logic [11:0]   flt_data_out,
    output logic          out_valid,
    output logic [11:0]   out_data,
    output logic [CW-1:0] out_x,
    output logic [CW-1:0] out_y,
    output logic          frame_start,
    output logic          frame_done,
    output logic          busy
);

    localparam int CNTW = $clog2(LAT + 1);
    localparam logic [CNTW-1:0] CFG_LAST = CNTW'(LAT - 1);
    localparam logic [CW-1:0]   X_LAST   = CW'(IMG_W - 1);
    localparam logic [CW-1:0]   Y_LAST   = CW'(IMG_H - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONFIG = 2'd1,
        RUN    = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    state_t          state, state_nx;
    logic [CNTW-1:0] cfg_cnt;
    logic [CW-1:0]   in_x, in_y;
    logic [LAT-1:0]  vsr;
    logic            rdy;
    logic            accept;
    logic            legal;
    logic            cfg_req;
    logic            in_last;
    logic            out_last;

    assign legal    = (freq_req == 3'b000) || (freq_req == 3'b010) || (freq_req == 3'b100);
    assign cfg_req  = legal && (freq_req != flt_freq_flag);
    assign in_last  = (in_x == X_LAST) && (in_y == Y_LAST);
    assign out_last = (out_x == X_LAST) && (out_y == Y_LAST);

    // Ready is forced low while reset is held, not just after the first edge.
    assign in_ready  = rdy & rst_n;
    assign accept    = in_valid & in_ready;
    assign out_valid = vsr[LAT-1];
    assign out_data  = out_valid ? flt_data_out : '0;
    assign busy      = (state != IDLE);

    always_comb begin
        state_nx = state;
        rdy      = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_req) begin
                    state_nx = CONFIG;
                end else begin
                    rdy = 1'b1;
                    if (accept) state_nx = in_last ? DRAIN : RUN;
                end
            end
            CONFIG: begin
                if (cfg_cnt == CFG_LAST) state_nx = IDLE;
            end
            RUN: begin
                rdy = 1'b1;
                if (accept && in_last) state_nx = DRAIN;
            end
            DRAIN: begin
                if (out_valid && out_last) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cfg_cnt       <= '0;
            flt_freq_flag <= '0;
            flt_data_in   <= '0;
            frame_start   <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            state       <= state_nx;
            cfg_cnt     <= (state == CONFIG) ? cfg_cnt + 1'b1 : '0;
            frame_start <= (state == IDLE) && accept;
            frame_done  <= (state == DRAIN) && out_valid && out_last;
            if (state == IDLE && cfg_req) flt_freq_flag <= freq_req;
            if (accept) flt_data_in <= in_data;
        end
    end

    // Input coordinates always rest at (0,0) in IDLE, so the same wrap logic
    // covers the first beat of a frame and the single-pixel frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_x <= '0;
            in_y <= '0;
        end else if (accept) begin
            if (in_x == X_LAST) begin
                in_x <= '0;
                in_y <= (in_y == Y_LAST) ? '0 : in_y + 1'b1;
            end else begin
                in_x <= in_x + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsr <= '0;
        end else begin
            vsr[0] <= accept;
            for (int unsigned i = 1; i < LAT; i++) vsr[i] <= vsr[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_x <= '0;
            out_y <= '0;
        end else if (out_valid) begin
            if (out_x == X_LAST) begin
                out_x <= '0;
                out_y <= (out_y == Y_LAST) ? '0 : out_y + 1'b1;
            end else begin
                out_x <= out_x + 1'b1;
            end
        end
    end

endmodule
